// File: rtl/fsm.sv
// fsm: one-shot load sequencer. Streams a static pattern and then a dynamic pattern
// out MSB first, then pulses en_fin once and parks in DONE until reset.
`default_nettype none

module fsm #(
  parameter int                    SIZESRSTAT   = 88,
  parameter int                    SIZESRDYN    = 16,
  parameter int                    SIZEADDRMUX  = 7,
  parameter logic [SIZESRSTAT-1:0] STAT_PATTERN = 88'hA5A5A5A5A5A5A5A5A5A5A5,
  parameter logic [SIZESRDYN-1:0]  DYN_PATTERN  = 16'hC3C3
) (
  input  logic CLK,
  input  logic RST_N,
  output logic sel_dyn,
  output logic sel_stat,
  output logic en_fin,
  output logic signal_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_STAT = 3'd1,
    LOAD_DYN  = 3'd2,
    FIN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [SIZEADDRMUX-1:0] STAT_LAST = SIZEADDRMUX'(SIZESRSTAT - 1);
  localparam logic [SIZEADDRMUX-1:0] DYN_LAST  = SIZEADDRMUX'(SIZESRDYN - 1);

  state_t                 state;
  logic [SIZEADDRMUX-1:0] cnt;
  logic [SIZESRSTAT-1:0]  stat_shifted;
  logic [SIZESRDYN-1:0]   dyn_shifted;

  // RST_N is active-high despite its name.
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= LOAD_STAT;
          cnt   <= '0;
        end
        LOAD_STAT: begin
          if (cnt == STAT_LAST) begin
            state <= LOAD_DYN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD_DYN: begin
          if (cnt == DYN_LAST) begin
            state <= FIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state <= DONE;
          cnt   <= '0;
        end
        DONE: begin
          state <= DONE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shifting left by cnt brings bit [SIZE-1-cnt] to the MSB without a narrow-index mux.
  assign stat_shifted = STAT_PATTERN << cnt;
  assign dyn_shifted  = DYN_PATTERN << cnt;

  always_comb begin
    sel_stat   = 1'b0;
    sel_dyn    = 1'b0;
    en_fin     = 1'b0;
    signal_out = 1'b0;
    case (state)
      LOAD_STAT: begin
        sel_stat   = 1'b1;
        signal_out = stat_shifted[SIZESRSTAT-1];
      end
      LOAD_DYN: begin
        sel_dyn    = 1'b1;
        signal_out = dyn_shifted[SIZESRDYN-1];
      end
      FIN: begin
        en_fin = 1'b1;
      end
      default: begin
        signal_out = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm.sv
// tb_fsm: directed checks of the fsm load sequence, serial data and reset behaviour.
`default_nettype none

module tb_fsm;

  logic CLK;
  logic RST_N;
  logic sel_dyn, sel_stat, en_fin, signal_out;

  int tests;
  int fails;
  int edges;
  int n_stat, n_dyn, n_fin;

  fsm dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .sel_dyn    (sel_dyn),
    .sel_stat   (sel_stat),
    .en_fin     (en_fin),
    .signal_out (signal_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_n;
    logic [3:0] exp;   // {sel_stat, sel_dyn, en_fin, signal_out}
  } vec_t;

  vec_t tbl[14];

  function automatic logic [3:0] outs();
    return {sel_stat, sel_dyn, en_fin, signal_out};
  endfunction

  // Expected outputs after the k-th rising edge following reset release.
  function automatic logic [3:0] exp_at(int k);
    logic [7:0] stat_seq;
    logic [7:0] dyn_seq;
    stat_seq = 8'b10100101;
    dyn_seq  = 8'b11000011;
    if (k <= 0)        return 4'b0000;
    else if (k <= 88)  return {3'b100, stat_seq[7 - ((k - 1) % 8)]};
    else if (k <= 104) return {3'b010, dyn_seq[7 - ((k - 89) % 8)]};
    else if (k == 105) return 4'b0010;
    else               return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (edge %0d): got %b, expected %b", name, edges, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to edge k, checking every cycle against the reference sequence.
  task automatic step_to(input int k);
    while (edges < k) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      n_stat += int'(sel_stat);
      n_dyn  += int'(sel_dyn);
      n_fin  += int'(en_fin);
      chk("per_cycle", outs(), exp_at(edges));
      tests++;
      if ((int'(sel_stat) + int'(sel_dyn) + int'(en_fin)) > 1 ||
          (!sel_stat && !sel_dyn && signal_out)) begin
        fails++;
        $display("FAIL exclusivity (edge %0d): got %b, expected one-hot or zero", edges, outs());
      end
    end
  endtask

  task automatic release_reset();
    RST_N  = 1'b0;
    edges  = 0;
    n_stat = 0;
    n_dyn  = 0;
    n_fin  = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    edges = 0;

    tbl[0]  = '{0,   4'b0000};
    tbl[1]  = '{1,   4'b1001};
    tbl[2]  = '{2,   4'b1000};
    tbl[3]  = '{5,   4'b1000};
    tbl[4]  = '{6,   4'b1001};
    tbl[5]  = '{8,   4'b1001};
    tbl[6]  = '{41,  4'b1001};
    tbl[7]  = '{88,  4'b1001};
    tbl[8]  = '{89,  4'b0101};
    tbl[9]  = '{91,  4'b0100};
    tbl[10] = '{95,  4'b0101};
    tbl[11] = '{104, 4'b0101};
    tbl[12] = '{105, 4'b0010};
    tbl[13] = '{106, 4'b0000};

    // Reset held for two edges: outputs stay 0.
    RST_N = 1'b1;
    #1;
    chk("reset_async", outs(), 4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("reset_hold", outs(), 4'b0000);
    end

    release_reset();
    #1;
    for (int i = 0; i < 14; i++) begin
      step_to(tbl[i].edge_n);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // 50+ cycles past DONE: nothing should move.
    step_to(160);
    chk_int("stat_len", n_stat, 88);
    chk_int("dyn_len",  n_dyn,  16);
    chk_int("fin_count", n_fin, 1);

    // Mid-LOAD_STAT abort at cnt = 40, then a full restart.
    RST_N = 1'b1;
    @(negedge CLK);
    release_reset();
    step_to(41);
    chk("pre_abort", outs(), 4'b1001);
    RST_N = 1'b1;
    #1;
    chk("abort_async", outs(), 4'b0000);
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_hold", outs(), 4'b0000);
    release_reset();
    step_to(110);
    chk_int("restart_stat_len", n_stat, 88);
    chk_int("restart_dyn_len",  n_dyn,  16);
    chk_int("restart_fin_count", n_fin, 1);

    // Abort during LOAD_DYN too, then confirm IDLE -> LOAD_STAT on the first edge.
    RST_N = 1'b1;
    @(negedge CLK);
    release_reset();
    step_to(95);
    RST_N = 1'b1;
    #1;
    chk("abort_dyn_async", outs(), 4'b0000);
    @(negedge CLK);
    release_reset();
    step_to(1);
    chk("restart_first", outs(), 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
